gen_leaky_relu_stage: RTL and testbench
=======================================

Name: gen_leaky_relu_stage

Overview:
Sequential LeakyReLU activation stage for the generator datapath, fed by the 128-neuron layer-3 fully-connected stage.
- Snapshots the layer's flattened Q8.8 output vector on start.
- Applies LeakyReLU (alpha about 0.2) to LANES elements per cycle.
- Presents the activated vector on a flattened output bus with a one-cycle done pulse, ready for the next layer's start.

Parameters:
- N_ELEM, 128: number of 16-bit elements in the vector.
- LANES, 4: elements processed per clock. N_ELEM must be divisible by LANES; violation is an elaboration error.
- ALPHA, 51: negative slope, Q8.8 signed 16-bit (51/256 = 0.199).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin processing. Sampled only in IDLE.
- in_flat  in  16*N_ELEM  signed Q8.8 input. Element i is at bits [16*i+15:16*i].
- out_flat  out  16*N_ELEM  signed Q8.8 activated vector, same packing as in_flat.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when out_flat is complete.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE, group counter=0, snapshot=0, out_flat=0, busy=0, done=0.
  - Applies mid-RUN as well: the operation is abandoned and no done is issued.
- States:
  - IDLE: on start, copy in_flat into the internal snapshot, set group=0, busy=1, go to RUN. Otherwise done=0.
  - RUN: each cycle, process elements group*LANES .. group*LANES+LANES-1 from the snapshot and write the results into out_flat.
    - If group == N_ELEM/LANES-1: go to DONE, busy=0.
    - Otherwise group+1.
  - DONE: done=1 for exactly this cycle, then IDLE.
- Latency: start sampled at edge k; last group written at edge k+N_ELEM/LANES; done high for the cycle after that edge.
  - Default parameters: done high for the cycle after edge k+32.
  - out_flat is fully valid whenever done=1 and remains stable until the next start.
- start while busy or in DONE: ignored, with no restart or queueing.
- in_flat may change after the start edge without affecting the result (snapshot).
- out_flat elements not yet rewritten keep their previous-run values during RUN. Consumers read out_flat only on or after done.
- Arithmetic per element x (signed 16-bit):
  - x >= 0: y = x.
  - x < 0: y = (x * ALPHA) >>> 8. The product is 32-bit signed; the shift is arithmetic (floor); y = product[23:8].
  - No saturation is needed: |y| <= |x| for ALPHA <= 256.
- Examples: -256 -> -51; -1 -> -1 (floor); -32768 -> -6528; 1000 -> 1000; 0 -> 0.

Decomposition:
- Shared package gan_fixed_pkg: DATA_W=16, FRAC_W=8, PROD_W=32, and the state encoding IDLE/RUN/DONE (2-bit).
- One natural sub-module, leaky_relu_q88: a purely combinational single lane (x, ALPHA -> y), instantiated LANES times via generate.
- Top level holds the FSM, counter, snapshot register and output register.

Test Plan:
1. All elements = 16'h0100 (+1.0), start for one cycle -> busy high 32 cycles; done pulses exactly one cycle after edge k+32; every out element = 16'h0100.
2. Element i = -256 for even i, 512 for odd i -> even outputs -51 (16'hFFCD), odd outputs 512 (16'h0200).
3. Boundary values in elements 0..3 = -1, -32768, 0, 32767 -> outputs -1, -6528, 0, 32767; elements 124..127 are processed in the last RUN cycle.
4. Change in_flat to all -256 one cycle after start, and pulse start again mid-RUN -> results still reflect the original snapshot; no restart; exactly one done pulse.
5. Assert rst at RUN cycle 10 -> next cycle out_flat=0, busy=0, done=0, state IDLE. A following start completes a full clean run with done at +33 cycles.
6. LANES=1 and LANES=128 builds with test 2 stimulus -> done after 129 and 2 cycles respectively; identical outputs.

Source files
------------

// File: rtl/gan_fixed_pkg.sv
// Shared fixed-point widths and sequencing states for the generator datapath stages.
package gan_fixed_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int PROD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gen_leaky_relu_stage_if.sv
// Start/vector/status bundle between the layer-3 stage, this activation and the next layer.
interface gen_leaky_relu_stage_if
   import gan_fixed_pkg::*;
#(
   parameter int N_ELEM = 128
);

   logic                       start;
   logic [DATA_W*N_ELEM-1:0]   in_flat;
   logic [DATA_W*N_ELEM-1:0]   out_flat;
   logic                       busy;
   logic                       done;

   modport master (
      output start,
      output in_flat,
      input  out_flat,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  in_flat,
      output out_flat,
      output busy,
      output done
   );

endinterface

// File: rtl/leaky_relu_q88.sv
// Single combinational LeakyReLU lane on Q8.8 data; negative inputs scale by alpha with floor.
module leaky_relu_q88
   import gan_fixed_pkg::*;
(
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] alpha,
   output logic signed [DATA_W-1:0] y
);

   // product[23:8] of the 32-bit signed product; >>> keeps the floor rounding
   assign y = x[DATA_W-1] ? DATA_W'((PROD_W'(x) * PROD_W'(alpha)) >>> FRAC_W) : x;

endmodule

// File: rtl/gen_leaky_relu_stage.sv
// Snapshots a Q8.8 vector on start and applies LeakyReLU LANES elements per clock.
//
//   state | meaning
//   IDLE  | waiting for start; out_flat holds the previous result
//   RUN   | one group of LANES elements written to out_flat per cycle
//   DONE  | single-cycle done pulse, out_flat complete
module gen_leaky_relu_stage
   import gan_fixed_pkg::*;
#(
   parameter int N_ELEM = 128,
   parameter int LANES  = 4,
   parameter int ALPHA  = 51
)(
   input  logic                   clk,
   input  logic                   rst,
   gen_leaky_relu_stage_if.slave  bus
);

   localparam int N_GROUPS = N_ELEM / LANES;
   localparam int GW       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam logic [GW-1:0]            LAST_GROUP = GW'(N_GROUPS - 1);
   localparam logic signed [DATA_W-1:0] ALPHA_Q    = DATA_W'(ALPHA);

   if (LANES < 1 || (N_ELEM % LANES) != 0) begin : g_bad_lanes
      $error("gen_leaky_relu_stage: N_ELEM must be a positive multiple of LANES");
   end

   state_t                     state, state_nxt;
   logic [GW-1:0]              grp, grp_nxt;
   logic [DATA_W*N_ELEM-1:0]   snap;
   logic [DATA_W*N_ELEM-1:0]   out_r;
   logic signed [DATA_W-1:0]   lane_x [LANES];
   logic signed [DATA_W-1:0]   lane_y [LANES];

   always_comb begin
      state_nxt = state;
      grp_nxt   = grp;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = RUN;
               grp_nxt   = '0;
            end
         end
         RUN: begin
            if (grp == LAST_GROUP) state_nxt = DONE;
            else                   grp_nxt   = grp + 1'b1;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_x[l] = snap[DATA_W*(int'(grp)*LANES + l) +: DATA_W];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      leaky_relu_q88 u_lane (
         .x     (lane_x[l]),
         .alpha (ALPHA_Q),
         .y     (lane_y[l])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grp   <= '0;
         snap  <= '0;
         out_r <= '0;
      end else begin
         state <= state_nxt;
         grp   <= grp_nxt;
         if (state == IDLE && bus.start) snap <= bus.in_flat;
         // untouched groups keep the previous run's results until rewritten
         if (state == RUN) begin
            for (int l = 0; l < LANES; l++) begin
               out_r[DATA_W*(int'(grp)*LANES + l) +: DATA_W] <= lane_y[l];
            end
         end
      end
   end

   assign bus.out_flat = out_r;
   assign bus.busy     = (state == RUN);
   assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_gen_leaky_relu_stage.sv
// Scoreboard bench: stimulus queues expected vectors and done cycles, per-DUT monitors check them.
module tb_gen_leaky_relu_stage;
   import gan_fixed_pkg::*;

   localparam int N = 128;
   localparam int W = DATA_W * N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int busy4 = 0;
   int done4 = 0;

   gen_leaky_relu_stage_if #(.N_ELEM(N)) m4 ();
   gen_leaky_relu_stage_if #(.N_ELEM(N)) m1 ();
   gen_leaky_relu_stage_if #(.N_ELEM(N)) m128 ();

   gen_leaky_relu_stage #(.N_ELEM(N), .LANES(4), .ALPHA(51)) dut4 (
      .clk (clk), .rst (rst), .bus (m4));
   gen_leaky_relu_stage #(.N_ELEM(N), .LANES(1), .ALPHA(51)) dut1 (
      .clk (clk), .rst (rst), .bus (m1));
   gen_leaky_relu_stage #(.N_ELEM(N), .LANES(128), .ALPHA(51)) dut128 (
      .clk (clk), .rst (rst), .bus (m128));

   typedef struct {
      logic [W-1:0] vec;
      int           due;
   } exp_t;

   exp_t q4[$], q1[$], q128[$];
   exp_t e4, e1, e128;

   function automatic void check_vec(string name, logic [W-1:0] act, logic [W-1:0] expv);
      int idx = -1;
      total++;
      if (act !== expv) begin
         bad++;
         for (int i = 0; i < N; i++)
            if (idx < 0 && act[DATA_W*i +: DATA_W] !== expv[DATA_W*i +: DATA_W]) idx = i;
         if (idx < 0) idx = 0;
         $display("FAIL %s: elem %0d got %h want %h", name, idx,
                  act[DATA_W*idx +: DATA_W], expv[DATA_W*idx +: DATA_W]);
      end
   endfunction

   function automatic void check_int(string name, int act, int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, expv);
      end
   endfunction

   function automatic logic [W-1:0] fill(logic [15:0] even_v, logic [15:0] odd_v);
      logic [W-1:0] v;
      for (int i = 0; i < N; i++) v[DATA_W*i +: DATA_W] = (i % 2 == 0) ? even_v : odd_v;
      return v;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (m4.busy) busy4++;
         if (m4.done) begin
            done4++;
            if (q4.size() == 0) begin
               total++; bad++;
               $display("FAIL done4_unexpected: got done at cycle %0d want none", cyc);
            end else begin
               e4 = q4.pop_front();
               check_vec("out4", m4.out_flat, e4.vec);
               check_int("done4_cycle", cyc, e4.due);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && m1.done) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL done1_unexpected: got done at cycle %0d want none", cyc);
         end else begin
            e1 = q1.pop_front();
            check_vec("out1", m1.out_flat, e1.vec);
            check_int("done1_cycle", cyc, e1.due);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && m128.done) begin
         if (q128.size() == 0) begin
            total++; bad++;
            $display("FAIL done128_unexpected: got done at cycle %0d want none", cyc);
         end else begin
            e128 = q128.pop_front();
            check_vec("out128", m128.out_flat, e128.vec);
            check_int("done128_cycle", cyc, e128.due);
         end
      end
   end

   // done is expected in the cycle after edge k+N/LANES, k being the start edge
   task automatic go(input int which, input logic [W-1:0] vec, input logic [W-1:0] expv);
      exp_t e;
      @(negedge clk);
      e.vec = expv;
      case (which)
         1: begin
            m1.in_flat = vec; m1.start = 1'b1;
            e.due = cyc + 1 + N; q1.push_back(e);
         end
         128: begin
            m128.in_flat = vec; m128.start = 1'b1;
            e.due = cyc + 1 + 1; q128.push_back(e);
         end
         default: begin
            m4.in_flat = vec; m4.start = 1'b1;
            e.due = cyc + 1 + N/4; q4.push_back(e);
         end
      endcase
      @(negedge clk);
      m4.start = 1'b0; m1.start = 1'b0; m128.start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && (q4.size() + q1.size() + q128.size()) > 0; i++)
         @(negedge clk);
      if ((q4.size() + q1.size() + q128.size()) > 0) begin
         total++; bad++;
         $display("FAIL done_timeout: got %0d pending want 0",
                  q4.size() + q1.size() + q128.size());
         q4.delete(); q1.delete(); q128.delete();
      end
   endtask

   logic [W-1:0] v3, x3;

   initial begin
      m4.start = 1'b0;   m4.in_flat = '0;
      m1.start = 1'b0;   m1.in_flat = '0;
      m128.start = 1'b0; m128.in_flat = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_vec("reset_out", m4.out_flat, '0);
      check_int("reset_busy", int'(m4.busy), 0);
      check_int("reset_done", int'(m4.done), 0);
      rst = 1'b0;

      // all +1.0
      busy4 = 0;
      go(4, fill(16'h0100, 16'h0100), fill(16'h0100, 16'h0100));
      wait_idle(60);
      check_int("busy_cycles", busy4, 32);

      // alternating -1.0 / +2.0
      go(4, fill(16'hFF00, 16'h0200), fill(16'hFFCD, 16'h0200));
      wait_idle(60);

      // boundary values up front, negatives in the last group
      for (int i = 0; i < N; i++) begin
         v3[DATA_W*i +: DATA_W] = 16'(i * 8);
         x3[DATA_W*i +: DATA_W] = 16'(i * 8);
      end
      v3[15:0]  = 16'hFFFF; x3[15:0]  = 16'hFFFF;
      v3[31:16] = 16'h8000; x3[31:16] = 16'hE680;
      v3[47:32] = 16'h0000; x3[47:32] = 16'h0000;
      v3[63:48] = 16'h7FFF; x3[63:48] = 16'h7FFF;
      for (int i = 124; i < N; i++) begin
         v3[DATA_W*i +: DATA_W] = 16'hFF00;
         x3[DATA_W*i +: DATA_W] = 16'hFFCD;
      end
      go(4, v3, x3);
      wait_idle(60);

      // snapshot isolation and start ignored mid-run
      done4 = 0;
      go(4, fill(16'hFE00, 16'hFE00), fill(16'hFF9A, 16'hFF9A));
      m4.in_flat = fill(16'hFF00, 16'hFF00);
      repeat (5) @(negedge clk);
      m4.start = 1'b1;
      @(negedge clk);
      m4.start = 1'b0;
      wait_idle(60);
      repeat (40) @(negedge clk);
      check_int("done_count", done4, 1);

      // reset abandons a run in progress
      go(4, fill(16'h0300, 16'hFD00), fill(16'h0300, 16'hFF67));
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q4.delete();
      check_vec("midrun_reset_out", m4.out_flat, '0);
      check_int("midrun_reset_busy", int'(m4.busy), 0);
      check_int("midrun_reset_done", int'(m4.done), 0);
      go(4, fill(16'h0300, 16'hFD00), fill(16'h0300, 16'hFF67));
      wait_idle(60);

      // single-lane and full-width builds
      go(1, fill(16'hFF00, 16'h0200), fill(16'hFFCD, 16'h0200));
      wait_idle(200);
      go(128, fill(16'hFF00, 16'h0200), fill(16'hFFCD, 16'h0200));
      wait_idle(20);
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
